// File: rtl/pc_pkg.sv
// pc_pkg: shared types and widths for the program-counter sequencer
package pc_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;
  localparam int LUT_AW = 4;
  localparam int PC_W = 10;
endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear, async reset
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign count = cnt_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: run/halt FSM and next-PC mux driving instruction-memory address.
// Define PC_PERF_EN to add saturating run_cycles / taken_count counters.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int            D        = PC_W,
  parameter logic [D-1:0]  START_PC = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [LUT_AW-1:0] branch_sel,
  input  logic              halt,
  output logic [LUT_AW-1:0] lut_addr,
  input  logic [D-1:0]      lut_target,
  output logic [D-1:0]      pc,
  output logic              running,
  output logic              done
`ifdef PC_PERF_EN
  ,
  output logic [15:0]       run_cycles,
  output logic [7:0]        taken_count
`endif
);
  pc_state_t    state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         running_q, done_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: state_d = start ? RUN : IDLE;
      RUN: begin
        // halt outranks stall, stall outranks branch
        if (halt) state_d = HALT;
        else if (!stall) pc_d = branch_en ? lut_target : pc_q + 1'b1;
      end
      HALT: if (start) begin
        state_d = RUN;
        pc_d    = START_PC;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= START_PC;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      running_q <= state_d == RUN;
      done_q    <= state_d == HALT;
    end
  assign lut_addr = branch_sel;
  assign pc       = pc_q;
  assign running  = running_q;
  assign done     = done_q;
`ifdef PC_PERF_EN
  logic perf_clr;
  assign perf_clr = state_q == HALT && start;
  sat_counter #(.W(16)) u_run_cycles (
    .clk(Clk), .rst(Reset), .inc(state_q == RUN), .clr(perf_clr), .count(run_cycles)
  );
  sat_counter #(.W(8)) u_taken_count (
    .clk(Clk), .rst(Reset), .inc(state_q == RUN && !halt && !stall && branch_en),
    .clr(perf_clr), .count(taken_count)
  );
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized run against a behavioural model
module tb_pc_sequencer;
  logic       Clk = 0, Reset = 1, start = 0, stall = 0, branch_en = 0, halt = 0;
  logic [3:0] branch_sel = 0, lut_addr;
  logic [9:0] lut_target, pc;
  logic       running, done;
`ifdef PC_PERF_EN
  logic [15:0] run_cycles;
  logic [7:0]  taken_count;
`endif
  logic [9:0] lut [16];
  int n_checks = 0, n_fail = 0;
  int m_mode, m_pc, m_run, m_taken;
  always #5 Clk = ~Clk;
  assign lut_target = lut[lut_addr];
  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .start(start), .stall(stall), .branch_en(branch_en),
    .branch_sel(branch_sel), .halt(halt), .lut_addr(lut_addr), .lut_target(lut_target),
    .pc(pc), .running(running), .done(done)
`ifdef PC_PERF_EN
    , .run_cycles(run_cycles), .taken_count(taken_count)
`endif
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_run = 0; m_taken = 0;
  endtask
  task automatic set_in(input logic s, input logic st, input logic b, input int sel, input logic h);
    start = s; stall = st; branch_en = b; branch_sel = 4'(sel); halt = h;
  endtask
  // mode: 0 idle, 1 run, 2 halt
  task automatic cyc();
    @(posedge Clk);
    if (m_mode == 1) begin
      m_run = m_run < 65535 ? m_run + 1 : m_run;
      if (halt) m_mode = 2;
      else if (!stall && branch_en) begin
        m_pc = lut[branch_sel];
        m_taken = m_taken < 255 ? m_taken + 1 : m_taken;
      end else if (!stall) m_pc = (m_pc + 1) % 1024;
    end else if (start) begin
      if (m_mode == 2) begin m_pc = 0; m_run = 0; m_taken = 0; end
      m_mode = 1;
    end
    @(negedge Clk);
    check("pc", pc, m_pc);
    check("running", running, m_mode == 1);
    check("done", done, m_mode == 2);
`ifdef PC_PERF_EN
    check("run_cycles", run_cycles, m_run);
    check("taken_count", taken_count, m_taken);
`endif
  endtask
  task automatic do_reset();
    #2 Reset = 1;
    #1;
    check("rst_pc", pc, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    model_reset();
    @(negedge Clk) Reset = 0;
  endtask
  initial begin
    foreach (lut[i]) lut[i] = 10'($urandom_range(0, 1023));
    lut[2] = 81; lut[3] = 20; lut[4] = 500; lut[5] = 37; lut[6] = 120; lut[7] = 1023;
    model_reset();
    @(negedge Clk);
    check("reset_pc", pc, 0);
    check("reset_running", running, 0);
    check("reset_done", done, 0);
    Reset = 0;
    cyc();
    check("idle_hold", pc, 0);
    set_in(1, 0, 0, 0, 0); cyc();
    check("t2_running", running, 1);
    set_in(0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin cyc(); check("t2_pc", pc, i); end
    set_in(0, 0, 1, 5, 0); cyc();
    check("t1_pc37", pc, 37);
    set_in(0, 0, 0, 0, 0);
    do_reset();
    set_in(1, 0, 0, 0, 0); cyc();
    set_in(0, 0, 1, 2, 0);
    #1 check("t3_lut_addr", lut_addr, 2);
    cyc(); check("t3_pc81", pc, 81);
    set_in(0, 0, 0, 0, 0); cyc(); check("t3_pc82", pc, 82);
    set_in(0, 0, 1, 3, 0); cyc(); check("t4_pc20", pc, 20);
    set_in(0, 1, 1, 4, 0); cyc(); check("t4_stalled", pc, 20);
    set_in(0, 0, 1, 4, 0); cyc(); check("t4_branch", pc, 500);
    set_in(0, 0, 1, 7, 0); cyc(); check("t6_pc1023", pc, 1023);
    set_in(0, 0, 0, 0, 0); cyc(); check("t6_wrap", pc, 0);
    set_in(1, 0, 0, 0, 0); cyc(); check("run_ignores_start", pc, 1);
    set_in(0, 0, 1, 6, 0); cyc(); check("t5_pc120", pc, 120);
    set_in(0, 0, 1, 4, 1); cyc();
    check("t5_halt_pc", pc, 120);
    check("t5_done", done, 1);
    check("t5_running", running, 0);
    set_in(0, 1, 1, 4, 1); cyc(); check("halt_ignores_in", pc, 120);
    set_in(1, 0, 0, 0, 0); cyc();
    check("t5_restart_pc", pc, 0);
    check("t5_restart_done", done, 0);
    check("t5_restart_run", running, 1);
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 15), $urandom_range(0, 31) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc();
    end
`ifdef PC_PERF_EN
    set_in(0, 0, 0, 0, 0);
    do_reset();
    set_in(1, 0, 0, 0, 0); cyc();
    set_in(0, 0, 0, 0, 0);
    repeat (300) cyc();
    check("perf_run300", run_cycles, 300);
    set_in(0, 0, 1, 3, 0);
    repeat (260) cyc();
    check("perf_taken_sat", taken_count, 255);
    set_in(0, 0, 0, 0, 1); cyc();
    set_in(1, 0, 0, 0, 0); cyc();
    check("perf_clr_run", run_cycles, 0);
    check("perf_clr_taken", taken_count, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
